// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ARM-style condition codes and NZCV flag bit positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator against a 4-bit {N,Z,C,V} flag vector.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic f_n;
  logic f_z;
  logic f_c;
  logic f_v;

  assign f_n = flags[FLAG_N];
  assign f_z = flags[FLAG_Z];
  assign f_c = flags[FLAG_C];
  assign f_v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = f_z;
      COND_NE: pass = !f_z;
      COND_CS: pass = f_c;
      COND_CC: pass = !f_c;
      COND_MI: pass = f_n;
      COND_PL: pass = !f_n;
      COND_VS: pass = f_v;
      COND_VC: pass = !f_v;
      COND_HI: pass = f_c & !f_z;
      COND_LS: pass = !f_c | f_z;
      COND_GE: pass = (f_n == f_v);
      COND_LT: pass = (f_n != f_v);
      COND_GT: pass = !f_z & (f_n == f_v);
      COND_LE: pass = f_z | (f_n != f_v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flag_stage.sv
// Execute-stage flag unit: registers the adder result, evaluates the condition and owns NZCV.
// Optional macro FLAG_BYPASS_EN forwards same-cycle flag updates to the decode query.
module ex_flag_stage
  import cpu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_sum,
  input  logic [3:0]    in_nzcv,
  input  logic          in_set_flags,
  input  logic [3:0]    in_cond,
  input  logic [3:0]    in_rd,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [3:0]    out_rd,
  output logic          out_we,
  output logic [3:0]    nzcv,
  input  logic [3:0]    q_cond,
  output logic          q_pass,
  output logic          flags_hazard
);

  logic       accept;
  logic       pipe_pass;
  logic       upd_flags;
  logic [3:0] q_flags;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready & !flush;

  // Incoming instruction is judged against flags from before its own update.
  cond_eval u_pipe_cond (
    .cond  (in_cond),
    .flags (nzcv),
    .pass  (pipe_pass)
  );

  assign upd_flags = accept & in_set_flags & pipe_pass;

`ifdef FLAG_BYPASS_EN
  assign q_flags      = upd_flags ? in_nzcv : nzcv;
  assign flags_hazard = 1'b0;
`else
  assign q_flags      = nzcv;
  assign flags_hazard = accept & in_set_flags;
`endif

  cond_eval u_query_cond (
    .cond  (q_cond),
    .flags (q_flags),
    .pass  (q_pass)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_we     <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      nzcv       <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
        out_we    <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        out_result <= in_sum;
        out_rd     <= in_rd;
        out_we     <= pipe_pass;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_we    <= 1'b0;
      end
      if (upd_flags) begin
        nzcv <= in_nzcv;
      end
    end
  end

endmodule

// File: doc/ex_flag_stage.md
EX_FLAG_STAGE -- requirements
Module: ex_flag_stage

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width of adder result.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  adder result/flags valid.
REQ-005 SHALL have port in_ready  output  1  stage accepts input this cycle.
REQ-006 SHALL have port in_sum  input  DW  adder sum.
REQ-007 SHALL have port in_nzcv  input  4  adder flags {N,Z,C,V}.
REQ-008 SHALL have port in_set_flags  input  1  instruction updates flags.
REQ-009 SHALL have port in_cond  input  4  instruction condition code.
REQ-010 SHALL have port in_rd  input  4  destination register index.
REQ-011 SHALL have port flush  input  1  discard held and incoming instruction.
REQ-012 SHALL have port out_valid  output  1  result held for next stage.
REQ-013 SHALL have port out_ready  input  1  next stage consumes result.
REQ-014 SHALL have port out_result  output  DW  registered sum.
REQ-015 SHALL have port out_rd  output  4  registered destination.
REQ-016 SHALL have port out_we  output  1  condition passed, write back.
REQ-017 SHALL have port nzcv  output  4  architectural flags register.
REQ-018 SHALL have port q_cond  input  4  decode-stage condition query.
REQ-019 SHALL have port q_pass  output  1  query result, combinational.
REQ-020 SHALL have port flags_hazard  output  1  decode must stall one cycle.

Function
REQ-021 SHALL drive in_ready = !out_valid | out_ready, and accept = in_valid & in_ready & !flush.
REQ-022 SHALL on accept capture in_sum, in_rd into out_result, out_rd and set out_valid next cycle (latency 1).
REQ-023 SHALL on accept set out_we = cond_eval(in_cond, nzcv) using flags before this instruction's update.
REQ-024 SHALL on accept with in_set_flags and condition passed load nzcv <= in_nzcv; failed condition leaves nzcv unchanged.
REQ-025 SHALL clear out_valid when out_ready is high and no accept occurs; hold all outputs while out_valid & !out_ready.
REQ-026 SHALL on flush clear out_valid and out_we next cycle, reject input that cycle, leave nzcv unchanged.
REQ-027 SHALL evaluate conditions: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
REQ-028 SHALL compute q_pass = cond_eval(q_cond, nzcv) combinationally from registered flags.
REQ-029 SHALL support back-to-back accepts each cycle when out_ready stays high, with each instruction evaluated against flags left by the previous one.

Reset
REQ-030 SHALL on reset clear out_valid, out_we, out_result, out_rd, nzcv to 0; reset overrides accept and flush.
REQ-031 SHALL drive in_ready high during and after reset (out_valid=0).

Configuration
REQ-032 SHALL with FLAG_BYPASS_EN defined evaluate q_pass against in_nzcv when an accept with in_set_flags and passing condition occurs in the same cycle, and tie flags_hazard to 0.
REQ-033 SHALL without FLAG_BYPASS_EN evaluate q_pass from registered nzcv only and assert flags_hazard in any cycle an accept with in_set_flags occurs.

Structure
REQ-034 SHALL take condition-code enum (EQ..NV) and NZCV bit-index constants (N=3,Z=2,C=1,V=0) from shared package cpu_pkg.
REQ-035 SHALL implement condition evaluation in one combinational sub-module cond_eval, instantiated twice (pipeline and query).

Verification
REQ-036 SHALL test: reset, then in_sum=0x0000_0005, nzcv_in=0000, cond=AL, set_flags=0, out_ready=1 -> next cycle out_valid=1, out_result=5, out_we=1, nzcv=0000.
REQ-037 SHALL test: accept set_flags=1 in_nzcv=0100 cond=AL, next cycle accept cond=EQ -> second out_we=1; follow with cond=NE -> out_we=0.
REQ-038 SHALL test: nzcv=1001 (N=1,V=1), queries GE, LT, GT, LE -> q_pass 1,0,1,0; cond NV -> 0 always.
REQ-039 SHALL test: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_result stable, nzcv unchanged, no input lost.
REQ-040 SHALL test: flush asserted with in_valid=1 set_flags=1 in_nzcv=1111 -> out_valid=0 next cycle, nzcv unchanged.
REQ-041 SHALL test: accept set_flags=1 in_nzcv=0100 with q_cond=EQ same cycle -> q_pass=1, flags_hazard=0 with FLAG_BYPASS_EN; q_pass=0, flags_hazard=1 without.
